// File: rtl/codec_pkg.sv
// codec_pkg: shared constants and types for the codec I2S record path
package codec_pkg;
   localparam int CODEC_DATA_WIDTH = 24;
   typedef struct packed {
      logic [CODEC_DATA_WIDTH-1:0] left;
      logic [CODEC_DATA_WIDTH-1:0] right;
   } stereo_sample_t;
   typedef enum logic [1:0] {IDLE, SYNC, LEFT, RIGHT} i2s_rx_state_e;
endpackage

// File: rtl/i2s_rx_fifo.sv
// i2s_rx_fifo: synchronous first-word-fall-through FIFO with occupancy count and sticky overflow
module i2s_rx_fifo #(
   parameter int W     = 48,
   parameter int DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     push,
   input  logic [W-1:0]             din,
   input  logic                     pop_req,
   input  logic                     clr,
   output logic [W-1:0]             dout,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   count,
   output logic                     overflow
);
   localparam int AW = $clog2(DEPTH);
   logic [W-1:0]  mem [DEPTH];
   logic [AW-1:0] wp, rp;
   logic          full, pop, wr;
   assign empty = count == '0;
   assign full  = count == (AW+1)'(DEPTH);
   assign pop   = pop_req & ~empty;
   // a pop in the same cycle frees the slot, so a full FIFO can still accept
   assign wr    = push & (~full | pop);
   assign dout  = empty ? '0 : mem[rp];
   always_ff @(posedge clk)
      if (wr) mem[wp] <= din;
   always_ff @(posedge clk or posedge reset)
      if (reset) begin
         wp       <= '0;
         rp       <= '0;
         count    <= '0;
         overflow <= 1'b0;
      end else begin
         wp       <= wp + AW'(wr);
         rp       <= rp + AW'(pop);
         count    <= count + (AW+1)'(wr) - (AW+1)'(pop);
         overflow <= (push & ~wr) | (overflow & ~clr);
      end
endmodule

// File: rtl/i2s_rx.sv
// i2s_rx: I2S record-path receiver; oversamples BCLK/LRCLK/DATA in clk domain and queues stereo pairs
module i2s_rx
   import codec_pkg::*;
#(
   parameter int DATA_WIDTH  = CODEC_DATA_WIDTH,
   parameter int FIFO_DEPTH  = 4,
   parameter int SYNC_STAGES = 2
) (
   input  logic                        clk,
   input  logic                        reset,
   input  logic                        enable,
   input  logic                        i2s_bclk,
   input  logic                        i2s_wclk,
   input  logic                        i2s_data,
   output logic [2*DATA_WIDTH-1:0]     data_out,
   output logic                        data_valid,
   input  logic                        data_rd,
   output logic [$clog2(FIFO_DEPTH):0] fifo_count,
   output logic                        overflow,
   input  logic                        overflow_clr,
   output logic                        frame_error
);
   localparam int CW = $clog2(DATA_WIDTH+1);
   logic [SYNC_STAGES-1:0] bclk_s, wclk_s, data_s;
   logic                   bclk, wclk, sdata, bclk_d, wclk_prev;
   logic                   strobe, rise, fall, in_slot, left_close, right_close, close, short_word, push, empty;
   i2s_rx_state_e          state, state_nx;
   logic [CW-1:0]          bit_cnt;
   logic [DATA_WIDTH-1:0]  shreg, left_word, word_fin;
   logic                   left_ok;
   assign bclk        = bclk_s[SYNC_STAGES-1];
   assign wclk        = wclk_s[SYNC_STAGES-1];
   assign sdata       = data_s[SYNC_STAGES-1];
   assign strobe      = bclk & ~bclk_d;
   assign rise        = strobe & wclk & ~wclk_prev;
   assign fall        = strobe & ~wclk & wclk_prev;
   assign in_slot     = enable & (state == LEFT || state == RIGHT);
   assign left_close  = enable & (state == LEFT) & rise;
   assign right_close = enable & (state == RIGHT) & fall;
   assign close       = left_close | right_close;
   // the transition bit is the closing slot's last bit, so it still counts toward the word
   assign short_word  = bit_cnt < CW'(DATA_WIDTH-1);
   assign word_fin    = bit_cnt < CW'(DATA_WIDTH) ? {shreg[DATA_WIDTH-2:0], sdata} : shreg;
   assign push        = right_close & left_ok & ~short_word;
   assign data_valid  = ~empty;
   always_comb begin
      state_nx = !enable ? IDLE :
                 state == IDLE ? SYNC :
                 (state == SYNC || state == RIGHT) && fall ? LEFT :
                 state == LEFT && rise ? RIGHT : state;
   end
   always_ff @(posedge clk or posedge reset)
      if (reset) begin
         bclk_s      <= '0;
         wclk_s      <= '0;
         data_s      <= '0;
         bclk_d      <= 1'b0;
         wclk_prev   <= 1'b0;
         state       <= IDLE;
         bit_cnt     <= '0;
         shreg       <= '0;
         left_word   <= '0;
         left_ok     <= 1'b0;
         frame_error <= 1'b0;
      end else begin
         bclk_s      <= {bclk_s[SYNC_STAGES-2:0], i2s_bclk};
         wclk_s      <= {wclk_s[SYNC_STAGES-2:0], i2s_wclk};
         data_s      <= {data_s[SYNC_STAGES-2:0], i2s_data};
         bclk_d      <= bclk;
         if (strobe) wclk_prev <= wclk;
         state       <= state_nx;
         frame_error <= close & short_word;
         if (!in_slot) begin
            bit_cnt <= '0;
            left_ok <= 1'b0;
         end else if (close) bit_cnt <= '0;
         else if (strobe && bit_cnt < CW'(DATA_WIDTH)) begin
            shreg   <= {shreg[DATA_WIDTH-2:0], sdata};
            bit_cnt <= bit_cnt + CW'(1);
         end
         if (left_close) begin
            left_word <= word_fin;
            left_ok   <= ~short_word;
         end else if (right_close) left_ok <= 1'b0;
      end
   i2s_rx_fifo #(.W(2*DATA_WIDTH), .DEPTH(FIFO_DEPTH)) u_fifo (
      .clk      (clk),
      .reset    (reset),
      .push     (push),
      .din      ({left_word, word_fin}),
      .pop_req  (data_rd),
      .clr      (overflow_clr),
      .dout     (data_out),
      .empty    (empty),
      .count    (fifo_count),
      .overflow (overflow)
   );
endmodule
